// File: rtl/demux_12_stream.sv
// Registered 1:2 stream demultiplexer: each input beat is steered by in_sel into one of two
// independent 2-entry output buffers, each with its own delivered-beat counter.
module demux_12_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

    occ_t             st   [2];
    logic [WIDTH-1:0] head [2];
    logic [WIDTH-1:0] tail [2];
    logic             vld  [2];
    logic [CNT_W-1:0] cnt  [2];
    logic [1:0]       push;
    logic [1:0]       pop;

    // Space check uses registered occupancy only; a same-cycle pop never frees a slot in TWO.
    assign in_ready = !rst && (in_sel ? (st[1] != TWO) : (st[0] != TWO));

    always_comb begin
        push    = '0;
        pop     = '0;
        push[0] = in_valid && in_ready && !in_sel;
        push[1] = in_valid && in_ready &&  in_sel;
        pop[0]  = vld[0] && out0_ready;
        pop[1]  = vld[1] && out1_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                st[k]   <= EMPTY;
                head[k] <= '0;
                tail[k] <= '0;
                vld[k]  <= 1'b0;
                cnt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                case (st[k])
                    EMPTY: begin
                        if (push[k]) begin
                            head[k] <= in_data;
                            vld[k]  <= 1'b1;
                            st[k]   <= ONE;
                        end
                    end
                    ONE: begin
                        if (push[k] && pop[k]) begin
                            head[k] <= in_data;
                        end else if (push[k]) begin
                            tail[k] <= in_data;
                            st[k]   <= TWO;
                        end else if (pop[k]) begin
                            vld[k]  <= 1'b0;
                            st[k]   <= EMPTY;
                        end
                    end
                    TWO: begin
                        if (pop[k]) begin
                            head[k] <= tail[k];
                            st[k]   <= ONE;
                        end
                    end
                    default: begin
                        vld[k] <= 1'b0;
                        st[k]  <= EMPTY;
                    end
                endcase
                if (pop[k]) begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end

    assign out0_data  = head[0];
    assign out0_valid = vld[0];
    assign out1_data  = head[1];
    assign out1_valid = vld[1];
    assign cnt0       = cnt[0];
    assign cnt1       = cnt[1];

endmodule

// File: tb/tb_demux_12_stream.sv
// Self-checking bench for demux_12_stream: directed scenarios plus randomized traffic,
// compared against a queue-based model of the two channels.
module tb_demux_12_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_sel = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out0_data;
    logic       out0_valid;
    logic       out0_ready = 1'b0;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready = 1'b0;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain FIFOs of capacity 2 plus delivered/pushed tallies.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int d0 = 0, d1 = 0, p0 = 0;

    demux_12_stream #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    function automatic logic model_ready(input logic s);
        return !rst && (s ? (q1.size() < 2) : (q0.size() < 2));
    endfunction

    task automatic model_clear();
        q0.delete(); q1.delete();
        d0 = 0; d1 = 0; p0 = 0;
    endtask

    // Called just after a rising edge: drive inputs, predict the transfer, step through the next edge.
    task automatic cycle(input logic v, input logic s, input logic [7:0] d,
                         input logic r0, input logic r1);
        logic pu, po0, po1;
        in_valid = v; in_sel = s; in_data = d; out0_ready = r0; out1_ready = r1;
        #1;
        pu  = v && model_ready(s);
        po0 = (q0.size() > 0) && r0;
        po1 = (q1.size() > 0) && r1;
        @(posedge clk);
        if (po0) begin void'(q0.pop_front()); d0++; end
        if (po1) begin void'(q1.pop_front()); d1++; end
        if (pu) begin
            if (s) q1.push_back(d);
            else begin q0.push_back(d); p0++; end
        end
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hFF;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b%b want 00", out0_valid, out1_valid);
        end
        n_checks++;
        if (cnt0 !== 8'd0 || cnt1 !== 8'd0 || out0_data !== 8'd0 || out1_data !== 8'd0) begin
            n_fail++; $display("FAIL reset_regs: cnt %0d/%0d data %h/%h want all 0", cnt0, cnt1, out0_data, out1_data);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single_route();
        do_reset();
        cycle(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
        n_checks++;
        if (out0_valid !== 1'b1 || out0_data !== 8'hA5) begin
            n_fail++; $display("FAIL route0: valid %b data %h want 1 a5", out0_valid, out0_data);
        end
        cycle(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
        n_checks++;
        if (out1_valid !== 1'b1 || out1_data !== 8'h3C || cnt0 !== 8'd1 || out0_valid !== 1'b0) begin
            n_fail++; $display("FAIL route1: v1 %b d1 %h cnt0 %0d v0 %b want 1 3c 1 0", out1_valid, out1_data, cnt0, out0_valid);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        n_checks++;
        if (cnt0 !== 8'd1 || cnt1 !== 8'd1) begin
            n_fail++; $display("FAIL route_cnt: got %0d/%0d want 1/1", cnt0, cnt1);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        cycle(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h33; #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_sel0: in_ready %b want 0", in_ready); end
        in_sel = 1'b1; #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_other_sel1: in_ready %b want 1", in_ready); end
        cycle(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
        n_checks++;
        if (out0_data !== 8'h11 || q0.size() != 2) begin
            n_fail++; $display("FAIL bp_hold: data %h want 11", out0_data);
        end
        cycle(1'b1, 1'b0, 8'h33, 1'b1, 1'b0);
        n_checks++;
        if (out0_valid !== 1'b1 || out0_data !== 8'h22) begin
            n_fail++; $display("FAIL bp_second: valid %b data %h want 1 22", out0_valid, out0_data);
        end
        cycle(1'b1, 1'b0, 8'h33, 1'b1, 1'b0);
        n_checks++;
        if (out0_valid !== 1'b1 || out0_data !== 8'h33) begin
            n_fail++; $display("FAIL bp_third: valid %b data %h want 1 33", out0_valid, out0_data);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (cnt0 !== 8'd3 || out0_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_cnt: cnt0 %0d valid %b want 3 0", cnt0, out0_valid);
        end
    endtask

    task automatic test_full_same_cycle_pop();
        do_reset();
        cycle(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h6B, 1'b0, 1'b0);
        in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h7C; out1_ready = 1'b1; #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_ready: in_ready %b want 0", in_ready); end
        cycle(1'b1, 1'b1, 8'h7C, 1'b0, 1'b1);
        n_checks++;
        if (out1_data !== 8'h6B || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL full_pop_second: data %h ready %b want 6b 1", out1_data, in_ready);
        end
        cycle(1'b1, 1'b1, 8'h7C, 1'b0, 1'b1);
        n_checks++;
        if (out1_valid !== 1'b1 || out1_data !== 8'h7C || cnt1 !== 8'd2) begin
            n_fail++; $display("FAIL full_pop_new: valid %b data %h cnt1 %0d want 1 7c 2", out1_valid, out1_data, cnt1);
        end
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_counter_wrap();
        int guard;
        do_reset();
        guard = 0;
        while (d0 < 257 && guard < 600) begin
            cycle(p0 < 257, 1'b0, 8'($urandom), 1'b1, 1'b0);
            guard++;
        end
        n_checks++;
        if (d0 != 257) begin n_fail++; $display("FAIL wrap_timeout: delivered %0d want 257", d0); end
        n_checks++;
        if (cnt0 !== 8'd1 || cnt1 !== 8'd0) begin
            n_fail++; $display("FAIL wrap_cnt: got %0d/%0d want 1/0", cnt0, cnt1);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        cycle(1'b1, 1'b0, 8'h99, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 8'h44, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
        in_valid = 1'b0; #2;
        rst = 1'b1; #1;
        n_checks++;
        if (out0_valid !== 1'b0 || cnt0 !== 8'd0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_async: valid %b cnt0 %0d ready %b want 0 0 0", out0_valid, cnt0, in_ready);
        end
        #1; rst = 1'b0;
        model_clear();
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        n_checks++;
        if (out0_valid !== 1'b0 || cnt0 !== 8'd0) begin
            n_fail++; $display("FAIL midrst_stale: valid %b cnt0 %0d want 0 0", out0_valid, cnt0);
        end
        cycle(1'b1, 1'b0, 8'hC3, 1'b0, 1'b0);
        n_checks++;
        if (out0_valid !== 1'b1 || out0_data !== 8'hC3) begin
            n_fail++; $display("FAIL midrst_first: valid %b data %h want 1 c3", out0_valid, out0_data);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 70, 1'($urandom), 8'($urandom),
                  $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 60);
            n_checks++;
            if (out0_valid !== (q0.size() > 0) || (q0.size() > 0 && out0_data !== q0[0])) begin
                n_fail++; $display("FAIL rand_out0 @%0d: valid %b data %h want valid %0d", i, out0_valid, out0_data, q0.size() > 0);
            end
            n_checks++;
            if (out1_valid !== (q1.size() > 0) || (q1.size() > 0 && out1_data !== q1[0])) begin
                n_fail++; $display("FAIL rand_out1 @%0d: valid %b data %h want valid %0d", i, out1_valid, out1_data, q1.size() > 0);
            end
            n_checks++;
            if (cnt0 !== 8'(d0) || cnt1 !== 8'(d1) || in_ready !== model_ready(in_sel)) begin
                n_fail++; $display("FAIL rand_cnt @%0d: cnt %0d/%0d ready %b want %0d/%0d %b",
                                   i, cnt0, cnt1, in_ready, 8'(d0), 8'(d1), model_ready(in_sel));
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_route();
        test_backpressure();
        test_full_same_cycle_pop();
        test_counter_wrap();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
